// File: rtl/skid_reg_ce.sv
// skid_reg_ce -- two-entry elastic register stage (skid buffer).
//
// Sits at the consuming end of a clock-enabled register pipeline. out_ready
// acts as the stage clock enable. No combinational path exists from in_* to
// out_*, or from out_ready to in_ready. in_ready depends only on the skid
// valid flop and RESET.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous, active-high reset
//   in_data    upstream data          in_valid  upstream valid
//   in_ready   stage can accept (registered, gated low by RESET)
//   out_data   downstream data (reg)  out_valid downstream valid (reg)
//   out_ready  downstream accepts / stage clock enable
//   count      occupancy 0..2 (reg), always M_v + S_v
module skid_reg_ce #(
    parameter int width = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // Main register M drives the output; skid register S holds the word
    // that was accepted while M was stalled.
    logic [width-1:0] m_data_q, m_data_d;
    logic             m_v_q,    m_v_d;
    logic [width-1:0] s_data_q, s_data_d;
    logic             s_v_q,    s_v_d;
    logic [1:0]       count_q,  count_d;

    logic in_fire;
    logic out_fire;

    always_comb begin
        in_ready = !s_v_q && !RESET;
        in_fire  = in_valid && in_ready;
        out_fire = m_v_q && out_ready;

        m_data_d = m_data_q;
        m_v_d    = m_v_q;
        s_data_d = s_data_q;
        s_v_d    = s_v_q;

        if (!m_v_q) begin
            // EMPTY
            if (in_fire) begin
                m_data_d = in_data;
                m_v_d    = 1'b1;
            end
        end else if (!s_v_q) begin
            // ONE
            if (in_fire && out_fire) begin
                m_data_d = in_data;
            end else if (in_fire) begin
                s_data_d = in_data;
                s_v_d    = 1'b1;
            end else if (out_fire) begin
                // Data left in M on purpose; only the valid bit drops.
                m_v_d = 1'b0;
            end
        end else begin
            // FULL: in_ready is low here, so only the drain case matters.
            // S is older than anything upstream, so it moves into M first.
            if (out_fire) begin
                m_data_d = s_data_q;
                s_v_d    = 1'b0;
            end
        end

        count_d = {1'b0, m_v_d} + {1'b0, s_v_d};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_data_q <= '0;
            m_v_q    <= 1'b0;
            s_data_q <= '0;
            s_v_q    <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            m_data_q <= m_data_d;
            m_v_q    <= m_v_d;
            s_data_q <= s_data_d;
            s_v_q    <= s_v_d;
            count_q  <= count_d;
        end
    end

    assign out_data  = m_data_q;
    assign out_valid = m_v_q;
    assign count     = count_q;

endmodule
